// File: rtl/day05_ram_arbiter_if.sv
// Requester-side bus of the Day 5 range RAM arbiter.
// Carries both requester channels: request/command inputs (req, we, lock,
// addr, wdata) and the grant/read-return outputs (gnt, rvalid, rdata).
//   master : requester side (drives commands, receives grants and read data)
//   slave  : arbiter side
interface day05_ram_arbiter_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 128
) ();
  logic                 req0,   req1;
  logic                 we0,    we1;
  logic                 lock0,  lock1;
  logic [ADDR_BITS-1:0] addr0,  addr1;
  logic [DATA_BITS-1:0] wdata0, wdata1;
  logic                 gnt0,   gnt1;
  logic                 rvalid0, rvalid1;
  logic [DATA_BITS-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/day05_ram_arbiter.sv
// Two-requester arbiter for the single-port range RAM (start in [127:64],
// end in [63:0]). Requester 0 is the range builder, requester 1 the ID
// lookup engine. Round-robin between requesters, with a lock that lets one
// requester run an uninterrupted multi-access sequence (e.g. a sort swap).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester channels (slave modport); gnt is combinational
//   ram_en/ram_we/ram_addr/ram_wdata : registered RAM command
//   ram_rdata  : RAM read data, valid the cycle after a read command
//   lock_err   : one-cycle pulse when an idle lock owner is forcibly released
module day05_ram_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 128,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  day05_ram_arbiter_if.slave   bus,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata,
  output logic                 lock_err
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  // Idle count seen in the cycle that completes the timeout.
  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

  state_t               state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 gnt0, gnt1;
  logic                 timeout_hit;
  logic                 own_req, own_lock;

  logic                 ram_en_q, ram_we_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [DATA_BITS-1:0] ram_wdata_q;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;

  logic                 vld_p0_q, vld_p1_q;
  logic                 own_p0_q, own_p1_q;
  logic                 vld_p0_d;

  assign own_req  = (state_q == LOCKED1) ? bus.req1  : bus.req0;
  assign own_lock = (state_q == LOCKED1) ? bus.lock1 : bus.lock0;

  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    if (!rst) begin
      case (state_q)
        UNLOCKED: begin
          cnt_d = '0;
          // On a tie, the requester that was not granted last wins.
          if (bus.req0 && (!bus.req1 || last_gnt_q)) gnt0 = 1'b1;
          else if (bus.req1)                         gnt1 = 1'b1;
          if (gnt0 && bus.lock0) state_d = LOCKED0;
          if (gnt1 && bus.lock1) state_d = LOCKED1;
        end
        LOCKED0, LOCKED1: begin
          gnt0 = (state_q == LOCKED0) && bus.req0;
          gnt1 = (state_q == LOCKED1) && bus.req1;
          if (own_req) begin
            // An owner request always beats the timeout in the same cycle.
            cnt_d = '0;
            if (!own_lock) state_d = UNLOCKED;
          end else if (cnt_q == LAST_IDLE) begin
            // This cycle is still arbitrated as locked; release takes effect next cycle.
            cnt_d       = '0;
            state_d     = UNLOCKED;
            timeout_hit = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
      if (gnt0) last_gnt_d = 1'b0;
      if (gnt1) last_gnt_d = 1'b1;
    end
  end

  assign sel_we    = gnt1 ? bus.we1    : bus.we0;
  assign sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
  assign vld_p0_d  = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      last_gnt_q  <= 1'b1;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      // Stage p0: command register, aligned with ram_en
      ram_en_q   <= gnt0 || gnt1;
      ram_we_q   <= (gnt0 || gnt1) && sel_we;
      if (gnt0 || gnt1) begin
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
      end
      vld_p0_q   <= vld_p0_d;
      // Stage p1: aligned with ram_rdata
      vld_p1_q   <= vld_p0_q;
    end
  end

  // Owner tags only matter when qualified by the valid bits.
  always_ff @(posedge clk) begin
    own_p0_q <= gnt1;
    own_p1_q <= own_p0_q;
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = vld_p1_q && !own_p1_q;
  assign bus.rvalid1 = vld_p1_q &&  own_p1_q;
  assign bus.rdata0  = ram_rdata;
  assign bus.rdata1  = ram_rdata;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign lock_err  = timeout_hit;

endmodule

// File: tb/tb_day05_ram_arbiter.sv
// Testbench for day05_ram_arbiter: table of per-cycle vectors from reset,
// then hand-written sequences for lock swap, lock timeout, write/read
// ordering and reset during an outstanding read.
module tb_day05_ram_arbiter;
  localparam int AB = 8;
  localparam int DB = 128;
  localparam int LT = 64;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  day05_ram_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  logic          ram_en, ram_we, lock_err;
  logic [AB-1:0] ram_addr;
  logic [DB-1:0] ram_wdata, ram_rdata;

  day05_ram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .LOCK_TIMEOUT(LT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .lock_err  (lock_err)
  );

  // Initial RAM contents: a distinct word per address.
  function automatic logic [DB-1:0] pat(input int i);
    logic [15:0] k;
    k = i[15:0];
    return {48'hC0DE_C0DE_0000, k, 48'h5EED_5EED_0000, k};
  endfunction

  // Single-port RAM model, one-cycle read latency.
  logic [DB-1:0] mem [256];
  logic [255:0]  wr_mask;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        wr_mask[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= wr_mask[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
      end
    end
    if (rst) wr_mask <= '0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checka(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkd(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1,
                       input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                       input logic [DB-1:0] d0, input logic [DB-1:0] d1);
    bus.req0 = r0;  bus.req1 = r1;
    bus.we0  = w0;  bus.we1  = w1;
    bus.lock0 = l0; bus.lock1 = l1;
    bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1;
  endtask

  task automatic idle();
    drive(L, L, L, L, L, L, 8'd0, 8'd0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic          r0, r1, w0;
    logic [AB-1:0] a0, a1;
    logic          g0, g1, en, we;
    logic [AB-1:0] addr;
    logic          rv0, rv1;
    int            rd;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1, input logic w0,
                              input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                              input logic g0, input logic g1, input logic en, input logic we,
                              input logic [AB-1:0] addr, input logic rv0, input logic rv1,
                              input int rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.en = en; v.we = we; v.addr = addr;
    v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
    return v;
  endfunction

  vec_t          tbl [14];
  logic          saw_g1, saw_err;
  logic [DB-1:0] aaaa;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    //           r0 r1 w0  a0      a1     g0 g1 en we  addr    rv0 rv1 rd
    tbl[0]  = mk(H, H, L, 8'd1,   8'd2,  H, L, L, L, 8'd0,   L, L, 0);
    tbl[1]  = mk(H, H, L, 8'd1,   8'd2,  L, H, H, L, 8'd1,   L, L, 0);
    tbl[2]  = mk(H, H, L, 8'd1,   8'd2,  H, L, H, L, 8'd2,   H, L, 1);
    tbl[3]  = mk(H, H, L, 8'd1,   8'd2,  L, H, H, L, 8'd1,   L, H, 2);
    tbl[4]  = mk(L, L, L, 8'd0,   8'd0,  L, L, H, L, 8'd2,   H, L, 1);
    tbl[5]  = mk(L, H, L, 8'd0,   8'd5,  L, H, L, L, 8'd2,   L, H, 2);
    tbl[6]  = mk(L, H, L, 8'd0,   8'd6,  L, H, H, L, 8'd5,   L, L, 0);
    tbl[7]  = mk(H, L, H, 8'd200, 8'd0,  H, L, H, L, 8'd6,   L, H, 5);
    tbl[8]  = mk(L, L, L, 8'd0,   8'd0,  L, L, H, H, 8'd200, L, H, 6);
    tbl[9]  = mk(L, L, L, 8'd0,   8'd0,  L, L, L, L, 8'd200, L, L, 0);
    tbl[10] = mk(H, H, L, 8'd8,   8'd9,  L, H, L, L, 8'd200, L, L, 0);
    tbl[11] = mk(H, L, L, 8'd8,   8'd0,  H, L, H, L, 8'd9,   L, L, 0);
    tbl[12] = mk(L, L, L, 8'd0,   8'd0,  L, L, H, L, 8'd8,   L, H, 9);
    tbl[13] = mk(L, L, L, 8'd0,   8'd0,  L, L, L, L, 8'd8,   H, L, 8);
    aaaa = {8{16'hAAAA}};

    // Reset state: grants gated while rst is high, command/valid outputs cleared.
    rst = 1'b1;
    drive(H, H, L, L, L, L, 8'd3, 8'd4, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset gnt0", bus.gnt0, L);
    check1("reset gnt1", bus.gnt1, L);
    check1("reset ram_en", ram_en, L);
    check1("reset ram_we", ram_we, L);
    checka("reset ram_addr", ram_addr, 8'd0);
    checkd("reset ram_wdata", ram_wdata, '0);
    check1("reset rvalid0", bus.rvalid0, L);
    check1("reset rvalid1", bus.rvalid1, L);
    check1("reset lock_err", lock_err, L);
    next_cycle();
    rst = 1'b0;

    // Table: contention, single requests, write without rvalid, RR history.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].w0, L, L, L, tbl[i].a0, tbl[i].a1, 128'hDEAD_BEEF, '0);
      @(negedge clk);
      check1($sformatf("v%0d gnt0", i), bus.gnt0, tbl[i].g0);
      check1($sformatf("v%0d gnt1", i), bus.gnt1, tbl[i].g1);
      check1($sformatf("v%0d ram_en", i), ram_en, tbl[i].en);
      check1($sformatf("v%0d ram_we", i), ram_we, tbl[i].we);
      checka($sformatf("v%0d ram_addr", i), ram_addr, tbl[i].addr);
      check1($sformatf("v%0d rvalid0", i), bus.rvalid0, tbl[i].rv0);
      check1($sformatf("v%0d rvalid1", i), bus.rvalid1, tbl[i].rv1);
      check1($sformatf("v%0d lock_err", i), lock_err, L);
      if (tbl[i].rv0) checkd($sformatf("v%0d rdata0", i), bus.rdata0, pat(tbl[i].rd));
      if (tbl[i].rv1) checkd($sformatf("v%0d rdata1", i), bus.rdata1, pat(tbl[i].rd));
      next_cycle();
    end

    // Locked swap of addresses 3 and 4 by requester 0 with requester 1 waiting.
    do_reset();
    drive(H, H, L, L, H, L, 8'd3, 8'd3, '0, '0);
    @(negedge clk);
    check1("swap rd3 gnt0", bus.gnt0, H);
    check1("swap rd3 gnt1", bus.gnt1, L);
    next_cycle();
    drive(H, H, L, L, H, L, 8'd4, 8'd3, '0, '0);
    @(negedge clk);
    check1("swap rd4 gnt0", bus.gnt0, H);
    check1("swap rd4 gnt1", bus.gnt1, L);
    next_cycle();
    drive(H, H, H, L, H, L, 8'd3, 8'd3, pat(4), '0);
    @(negedge clk);
    check1("swap wr3 gnt0", bus.gnt0, H);
    check1("swap wr3 gnt1", bus.gnt1, L);
    check1("swap rd3 rvalid0", bus.rvalid0, H);
    checkd("swap rd3 rdata0", bus.rdata0, pat(3));
    next_cycle();
    drive(H, H, H, L, L, L, 8'd4, 8'd3, pat(3), '0);
    @(negedge clk);
    check1("swap wr4 gnt0", bus.gnt0, H);
    check1("swap wr4 gnt1", bus.gnt1, L);
    check1("swap rd4 rvalid0", bus.rvalid0, H);
    checkd("swap rd4 rdata0", bus.rdata0, pat(4));
    next_cycle();
    drive(L, H, L, L, L, L, 8'd0, 8'd3, '0, '0);
    @(negedge clk);
    check1("swap after unlock gnt1", bus.gnt1, H);
    check1("swap after unlock gnt0", bus.gnt0, L);
    check1("swap write no rvalid0", bus.rvalid0, L);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    check1("swap readback rvalid1", bus.rvalid1, H);
    checkd("swap readback rdata1", bus.rdata1, pat(4));
    next_cycle();

    // Lock timeout: one locked access, owner idle, requester 1 waiting.
    do_reset();
    drive(H, H, L, L, H, L, 8'd10, 8'd11, '0, '0);
    @(negedge clk);
    check1("timeout lock access gnt0", bus.gnt0, H);
    next_cycle();
    drive(L, H, L, L, L, L, 8'd0, 8'd11, '0, '0);
    saw_g1  = 1'b0;
    saw_err = 1'b0;
    for (int c = 1; c <= LT; c++) begin
      @(negedge clk);
      if (bus.gnt1) saw_g1 = 1'b1;
      if (c < LT && lock_err) saw_err = 1'b1;
      if (c == LT) check1("timeout lock_err pulse", lock_err, H);
      next_cycle();
    end
    check1("timeout gnt1 while locked", saw_g1, L);
    check1("timeout early lock_err", saw_err, L);
    @(negedge clk);
    check1("timeout gnt1 after release", bus.gnt1, H);
    check1("timeout lock_err one cycle", lock_err, L);
    next_cycle();

    // Owner request in the cycle the timeout would expire wins and keeps the lock.
    do_reset();
    drive(H, L, L, L, H, L, 8'd10, 8'd0, '0, '0);
    next_cycle();
    drive(L, H, L, L, L, L, 8'd0, 8'd11, '0, '0);
    repeat (LT - 1) next_cycle();
    drive(H, H, L, L, H, L, 8'd12, 8'd11, '0, '0);
    @(negedge clk);
    check1("late owner gnt0", bus.gnt0, H);
    check1("late owner no lock_err", lock_err, L);
    next_cycle();
    drive(L, H, L, L, L, L, 8'd0, 8'd11, '0, '0);
    @(negedge clk);
    check1("late owner still locked gnt1", bus.gnt1, L);
    next_cycle();

    // Write by requester 0 then immediate read by requester 1 of the same address.
    do_reset();
    drive(H, L, H, L, L, L, 8'd7, 8'd0, aaaa, '0);
    @(negedge clk);
    check1("order write gnt0", bus.gnt0, H);
    next_cycle();
    drive(L, H, L, L, L, L, 8'd0, 8'd7, '0, '0);
    @(negedge clk);
    check1("order read gnt1", bus.gnt1, H);
    next_cycle();
    idle();
    @(negedge clk);
    check1("order t+2 rvalid1", bus.rvalid1, L);
    next_cycle();
    @(negedge clk);
    check1("order t+3 rvalid1", bus.rvalid1, H);
    checkd("order t+3 rdata1", bus.rdata1, aaaa);
    next_cycle();

    // Reset in the cycle after a locked read grant.
    do_reset();
    drive(H, L, L, L, H, L, 8'd5, 8'd0, '0, '0);
    @(negedge clk);
    check1("rstmid read gnt0", bus.gnt0, H);
    next_cycle();
    rst = 1'b1;
    drive(H, H, L, L, L, L, 8'd6, 8'd7, '0, '0);
    @(negedge clk);
    check1("rstmid gnt0 in reset", bus.gnt0, L);
    check1("rstmid gnt1 in reset", bus.gnt1, L);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check1("rstmid rvalid0", bus.rvalid0, L);
    check1("rstmid ram_en", ram_en, L);
    check1("rstmid ram_we", ram_we, L);
    checka("rstmid ram_addr", ram_addr, 8'd0);
    checkd("rstmid ram_wdata", ram_wdata, '0);
    check1("rstmid lock_err", lock_err, L);
    check1("rstmid tie gnt0", bus.gnt0, H);
    check1("rstmid tie gnt1", bus.gnt1, L);
    next_cycle();
    idle();
    @(negedge clk);
    check1("rstmid late rvalid0", bus.rvalid0, L);
    next_cycle();
    @(negedge clk);
    check1("rstmid new rvalid0", bus.rvalid0, H);
    checkd("rstmid new rdata0", bus.rdata0, pat(6));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/day05_ram_arbiter.md
# day05_ram_arbiter

Two-requester arbiter that shares one single-port range RAM (128-bit words: start in [127:64], end in [63:0]) between the Day 5 range builder (requester 0: parse/sort/merge) and the ID lookup engine (requester 1: binary search). It issues registered commands to the RAM and routes read data back to the issuing requester. Round-robin fairness applies between requesters. A lock lets one requester perform multi-access atomic sequences, such as a sort swap (read, read, write, write), without interleaving.

## Interface
- ADDR_BITS, 8, RAM address width
- DATA_BITS, 128, RAM word width
- LOCK_TIMEOUT, 64, idle cycles of the lock owner before the lock is forcibly released
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0/req1  in  1  access request
- we0/we1  in  1  1 = write, 0 = read
- lock0/lock1  in  1  acquire or hold the lock with this access
- addr0/addr1  in  ADDR_BITS  access address
- wdata0/wdata1  in  DATA_BITS  write data
- gnt0/gnt1  out  1  combinational; access accepted this cycle
- rvalid0/rvalid1  out  1  read data valid for this requester
- rdata0/rdata1  out  DATA_BITS  read data; both equal ram_rdata, qualified by rvalid
- ram_en, ram_we  out  1  registered RAM command
- ram_addr  out  ADDR_BITS  registered
- ram_wdata  out  DATA_BITS  registered
- ram_rdata  in  DATA_BITS  RAM output, valid one cycle after the cycle ram_en is high for a read
- lock_err  out  1  one-cycle pulse on a forced lock release

## Operation
- States: UNLOCKED, LOCKED0, LOCKED1. Reset enters UNLOCKED with last_gnt = 1, so requester 0 wins the first tie.
- UNLOCKED arbitration:
  - Only one req high: that requester is granted.
  - Both high: grant goes to the requester other than last_gnt.
  - last_gnt updates on every grant.
- LOCKED_n:
  - Only requester n can be granted. The other requester's req is held pending, with no grant.
- Lock transitions:
  - An accepted access with lock = 1 from UNLOCKED moves to LOCKED_n.
  - An accepted access with lock = 0 in LOCKED_n returns to UNLOCKED. That access is still performed.
- Timeout:
  - A counter clears on each accepted owner access.
  - It increments on each LOCKED cycle with no owner request.
  - On reaching LOCKED_TIMEOUT, the state goes to UNLOCKED and lock_err pulses for one cycle. That cycle is still arbitrated as LOCKED.
- At most one grant per cycle; gnt0 & gnt1 is never 1.
- Read tag pipeline: a 2-stage shift of {valid, owner}. rvalid_n is high in exactly the cycle ram_rdata belongs to requester n's read.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle (full throughput).
- Data is forwarded unmodified; the arbiter does no width conversion.

## Timing
- Cycle t: req_n high and gnt_n high (combinational).
- Edge t→t+1: ram_en = 1, ram_we/addr/wdata are loaded from requester n. With no grant, ram_en = ram_we = 0 and addr/wdata hold.
- Cycle t+2: for a read, rvalid_n = 1 and rdata_n = ram_rdata. Read latency from grant is 2 cycles.
- A write at cycle t followed by a read of the same address at t+1 (either requester) returns the new data. RAM ordering is preserved because commands issue in grant order.
- Reset values: gnt0/1 = 0 while rst is high, rvalid0/1 = 0, ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, lock_err = 0, state UNLOCKED, timeout counter 0.
- Reset mid-operation:
  - In-flight reads are discarded; no rvalid is produced after the reset edge.
  - Any held lock is dropped without lock_err.
- Simultaneous owner release (lock = 0 access) and other-requester req: the release access is granted this cycle. The other requester wins in the next cycle.
- Timeout in the same cycle the owner requests: the request is granted and the counter clears. No timeout occurs.

## Test plan
- Single read: req1 = 1, addr1 = 5, cycle 10. Required: gnt1 in cycle 10, ram_en/ram_addr = 5 in cycle 11, rvalid1 in cycle 12 with rdata1 = RAM[5], rvalid0 = 0 throughout.
- Contention: req0 = req1 = 1 for 4 cycles after reset, all reads. Required: grants 0, 1, 0, 1; rvalid0/rvalid1 alternate starting 2 cycles later.
- Locked swap: requester 0 issues read 3 (lock), read 4 (lock), write 3 (lock), write 4 (lock = 0) while req1 = 1 continuously. Required: gnt1 = 0 during all four accesses. gnt1 = 1 in the cycle after the unlocking write. A subsequent requester 1 read of address 3 returns the old RAM[4].
- Lock timeout: requester 0 makes one locked access then idles, req1 held high, LOCK_TIMEOUT = 64. Required: lock_err pulses once 64 cycles after the locked access. gnt1 is asserted in the following cycle.
- Write/read ordering: requester 0 writes 0xAAAA… to address 7 in cycle t; requester 1 reads address 7 in cycle t+1. Required: rdata1 = 0xAAAA… with rvalid1 in cycle t+3.
- Reset mid-read: rst asserted in the cycle after gnt0 for a read. Required: no rvalid0, all RAM command outputs 0, and a tied req0/req1 after release grants requester 0 first.
